// File: rtl/svk_rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package svk_rst_seq_pkg;

  // Sequencer FSM states. POR is a RELEASE pass over every output using
  // the default gap.
  typedef enum logic [1:0] {
    ST_POR     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_RELEASE = 2'd3
  } svk_rst_seq_state_e;

  localparam int unsigned STATE_W = 2;

  // Index width for a vector of n resets, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/svk_rst_seq_ffs.sv
// Lowest-set-bit finder: one-hot of the lowest set bit plus a flag that is
// high when exactly one bit is set (the release about to happen is the last).
module svk_rst_seq_ffs
  import svk_rst_seq_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] low,
  output logic         single
);

  // Two's-complement trick isolates the lowest set bit; clearing it and
  // testing for zero tells whether it was the only one.
  always_comb begin
    low    = vec & (~vec + N'(1));
    single = (vec != '0) && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/svk_rst_seq.sv
// Synchronous reset sequencer. After power-on it releases every output in
// ascending order with a fixed gap; on request it re-asserts a subset, holds
// it for D cycles and releases it one output at a time, D cycles apart.
//
// Request handshake: a request is accepted on a rising edge where
// req_valid && req_ready; req_mask and req_dly are sampled only on that
// edge. req_ready is high exactly while the FSM is idle, so valid may be
// held high across done to chain requests back to back.
module svk_rst_seq
  import svk_rst_seq_pkg::*;
#(
  parameter int unsigned RST_NUM     = 4,
  parameter int unsigned DLY_W       = 8,
  parameter int unsigned DEFAULT_DLY = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [RST_NUM-1:0] req_mask,
  input  logic [DLY_W-1:0]   req_dly,
  output logic [RST_NUM-1:0] rst_out_n,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] dbg_state
);

  svk_rst_seq_state_e state;
  logic [DLY_W-1:0]   cnt;
  logic [DLY_W-1:0]   dly;
  logic [DLY_W-1:0]   dly_eff;
  logic [RST_NUM-1:0] pend;
  logic [RST_NUM-1:0] low_bit;
  logic               last_bit;

  svk_rst_seq_ffs #(.N(RST_NUM)) u_ffs (
    .vec    (pend),
    .low    (low_bit),
    .single (last_bit)
  );

  // A zero delay request still holds and spaces by one cycle.
  always_comb begin
    dly_eff = (req_dly == '0) ? DLY_W'(1) : req_dly;
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Sequencer FSM: counter, pending mask, reset outputs and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_POR;
      cnt       <= DLY_W'(DEFAULT_DLY - 1);
      dly       <= DLY_W'(DEFAULT_DLY);
      pend      <= '1;
      rst_out_n <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_mask == '0) begin
              done <= 1'b1;
            end else begin
              state     <= ST_ASSERT;
              pend      <= req_mask;
              dly       <= dly_eff;
              cnt       <= dly_eff - DLY_W'(1);
              rst_out_n <= rst_out_n & ~req_mask;
            end
          end
        end
        // POR, ASSERT and RELEASE share the count-down-then-release step.
        default: begin
          if (cnt != '0) begin
            cnt <= cnt - DLY_W'(1);
          end else begin
            rst_out_n <= rst_out_n | low_bit;
            pend      <= pend & ~low_bit;
            cnt       <= dly - DLY_W'(1);
            if (last_bit || (pend == '0)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svk_rst_seq.sv
// Testbench for svk_rst_seq: per-cycle expected words
// {rst_out_n, done, busy, req_ready} are queued when stimulus is driven and
// compared every falling edge.
module tb_svk_rst_seq;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int DD = 16;
  localparam int W  = N + 3;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [N-1:0]  req_mask;
  logic [DW-1:0] req_dly;
  logic [N-1:0]  rst_out_n;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  svk_rst_seq #(.RST_NUM(N), .DLY_W(DW), .DEFAULT_DLY(DD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mask  (req_mask),
    .req_dly   (req_dly),
    .rst_out_n (rst_out_n),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [N-1:0] cur_r;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got={rst,done,busy,rdy}=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] w;
      string        t;
      w = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {rst_out_n, done, busy, req_ready}, w);
    end
  end

  function automatic logic [W-1:0] idle_w(input logic [N-1:0] r);
    return {r, 3'b001};
  endfunction

  function automatic logic [W-1:0] rst_w();
    return {{N{1'b0}}, 3'b010};
  endfunction

  task automatic push(input logic [W-1:0] w, input string tag);
    exp_q.push_back(w);
    tag_q.push_back(tag);
  endtask

  // Expected samples after accept edge A+j, j = 0..min(D*m, upto):
  // the i-th masked bit (ascending) rises at edge A + D*(i+1); done at D*m.
  task automatic push_trace(input logic [N-1:0] r0, input logic [N-1:0] mask,
                            input int dly, input int upto, input string tag);
    int           d;
    int           m;
    int           rank[N];
    logic [N-1:0] r;
    d = (dly == 0) ? 1 : dly;
    m = 0;
    for (int i = 0; i < N; i++) begin
      rank[i] = m;
      if (mask[i]) m++;
    end
    for (int j = 0; j <= d * m && j <= upto; j++) begin
      r = r0;
      for (int i = 0; i < N; i++)
        if (mask[i]) r[i] = (j >= d * (rank[i] + 1));
      push({r, (j == d * m), (j < d * m), !(j < d * m)}, tag);
    end
  endtask

  // Waits for the queue to drain; optionally scrambles mask/dly meanwhile,
  // which must be ignored while valid is low or the block is busy.
  task automatic wait_drain(input int budget, input bit wiggle);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      if (wiggle) begin
        req_mask = N'($urandom_range(0, (1 << N) - 1));
        req_dly  = DW'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", W'(exp_q.size()), '0);
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_req(input logic [N-1:0] mask, input int dly, input string tag);
    req_valid = 1'b1;
    req_mask  = mask;
    req_dly   = DW'(dly);
    push(idle_w(cur_r), {tag, "_pre"});
    push_trace(cur_r, mask, dly, 1 << 20, tag);
    cur_r = cur_r | mask;
    for (int i = 0; i < 3; i++) push(idle_w(cur_r), {tag, "_idle"});
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain(400, 1'b1);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_mask  = '0;
    req_dly   = '0;
    cur_r     = '0;

    // Power-on: five low edges, then the full default-gap release sequence.
    repeat (4) @(posedge clk);
    #1;
    push(rst_w(), "reset_state");
    push_trace('0, '1, DD, 1 << 20, "por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur_r = '1;
    for (int i = 0; i < 3; i++) push(idle_w(cur_r), "por_idle");
    wait_drain(200, 1'b0);

    do_req(4'b0101, 3, "req_0101_d3");
    do_req(4'b0000, 5, "req_mask0");
    do_req(4'b1000, 0, "req_d0");

    // Back-to-back: valid held high through the first done cycle.
    req_valid = 1'b1;
    req_mask  = 4'b0011;
    req_dly   = DW'(2);
    push(idle_w(cur_r), "b2b_pre");
    push_trace(cur_r, 4'b0011, 2, 1 << 20, "b2b_first");
    push_trace(cur_r, 4'b0011, 2, 1 << 20, "b2b_second");
    for (int i = 0; i < 3; i++) push(idle_w(cur_r), "b2b_idle");
    repeat (6) @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_drain(100, 1'b0);

    // Reset in the middle of a request, then a fresh POR.
    req_valid = 1'b1;
    req_mask  = 4'b1111;
    req_dly   = DW'(10);
    push(idle_w(cur_r), "midrst_pre");
    push_trace(cur_r, 4'b1111, 10, 10, "midrst_req");
    push(rst_w(), "midrst_reset");
    push_trace('0, '1, DD, 1 << 20, "midrst_por");
    cur_r = '1;
    for (int i = 0; i < 3; i++) push(idle_w(cur_r), "midrst_idle");
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_drain(200, 1'b0);

    // Random requests.
    for (int n = 0; n < 6; n++)
      do_req(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 5), "rand_req");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/svk_rst_seq.md
Name: svk_rst_seq

Overview:
- Synchronous reset sequencer, sitting directly downstream of the CRG clock/reset interface.
- Consumes one CRG clock and its reset.
- Drives RST_NUM ordered active-low reset outputs into DUT sub-blocks:
  - On power-on: releases every output in ascending index order, with a fixed gap between releases.
  - On a request: re-asserts a selected subset, holds it, then releases it one output at a time with a programmable gap.

Parameters:
- RST_NUM, 4, number of sequenced reset outputs (1..32).
- DLY_W, 8, width of the delay configuration and internal counter.
- DEFAULT_DLY, 16, gap in cycles used by the power-on sequence (1..2^DLY_W-1).

Ports:
- clk, input, 1, single block clock.
- rst_n, input, 1, synchronous active-low reset.
- req_valid, input, 1, sequence request valid.
- req_ready, output, 1, block can accept a request.
- req_mask, input, RST_NUM, outputs to re-sequence; sampled on accept.
- req_dly, input, DLY_W, hold/gap length in cycles; sampled on accept.
- rst_out_n, output, RST_NUM, sequenced active-low resets.
- busy, output, 1, sequence in progress (POR or request).
- done, output, 1, one-cycle pulse when a sequence completes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values while rst_n=0:
  - rst_out_n all 0; busy=1; req_ready=0; done=0.
  - State POR; cnt=DEFAULT_DLY-1; pending mask = all ones.
- States: POR, IDLE, ASSERT, RELEASE.
  - POR behaves exactly like RELEASE, with mask = all ones and D = DEFAULT_DLY.
- req_ready = (state==IDLE). busy = (state!=IDLE). An accept occurs when req_valid && req_ready at a rising edge.
- On accept:
  - Latch pend = req_mask and D = max(req_dly, 1). A req_dly of 0 is treated as 1.
  - If req_mask == 0: stay IDLE, pulse done on the next cycle, leave rst_out_n unchanged.
  - Otherwise: next state ASSERT, rst_out_n[i] <= 0 for every set pend bit, cnt <= D-1.
- ASSERT:
  - cnt decrements each cycle.
  - When cnt==0: release the lowest set bit of pend (rst_out_n[k] <= 1), clear it from pend, cnt <= D-1, go to RELEASE.
  - Each masked output is therefore low for exactly D cycles before the first release.
- RELEASE (and POR):
  - cnt decrements each cycle.
  - When cnt==0 and pend is non-zero: release the lowest set pend bit, clear it, cnt <= D-1.
  - When the bit just released was the last one, the same edge moves the state to IDLE and registers done=1 for one cycle.
  - done is therefore coincident with the final rst_out_n rising edge, and req_ready is high in that same cycle.
- Release spacing: D cycles between consecutive rising edges of rst_out_n. Release order is strictly ascending index among the masked bits.
- Unmasked outputs hold their value throughout the sequence.
- Request gating: req_mask/req_dly changes while busy are ignored. req_valid held high across done is accepted on the first IDLE cycle, so back-to-back requests are legal.
- Reset mid-operation: rst_n=0 in any state forces every output to its reset value the next edge. Any in-flight request is discarded and no done pulse is produced for it; POR restarts once rst_n returns high.
- POR timing: first release on the DEFAULT_DLY-th edge after rst_n deasserts; last release (RST_NUM-1)*DEFAULT_DLY cycles later.
- Counter: DLY_W bits, no wrap possible since it is loaded with D-1 ≤ 2^DLY_W-2 before counting down to 0.

Decomposition:
- Package svk_rst_seq_pkg:
  - state enum svk_rst_seq_state_e {POR, IDLE, ASSERT, RELEASE}.
  - Localparam helper for the index width: $clog2(RST_NUM), minimum 1.
- Sub-module svk_rst_seq_ffs: combinational lowest-set-bit finder, parameterised by RST_NUM. Outputs a one-hot of the lowest set bit and an "only one bit set" flag, which is used for last-release detection.

Test Plan:
- POR, RST_NUM=4, DEFAULT_DLY=16: hold rst_n low 5 cycles, then release it.
  - rst_out_n bits rise in order 0,1,2,3 at edges 16, 32, 48, 64 after deassert.
  - done pulses at edge 64; busy falls in the same cycle.
- Request mask=4'b0101, dly=3, accepted at edge 0:
  - Bits 0 and 2 go low at edge 1.
  - Bit 0 rises at edge 4; bit 2 rises at edge 7 with done=1.
  - Bits 1 and 3 stay 1 throughout.
- Request mask=0, dly=5: done pulses 1 cycle after accept, rst_out_n stays 4'b1111, req_ready never drops.
- Request mask=4'b1000, dly=0: bit 3 is low for exactly 1 cycle, done coincides with its rise; checks the D=max(dly,1) rule.
- Reset mid-sequence: request mask=4'b1111, dly=10; assert rst_n low at edge 12.
  - All outputs go 0 at the next edge; no done for the aborted request.
  - A full POR sequence follows release of rst_n.
- Back-to-back: req_valid held high with mask=4'b0011, dly=2.
  - A second accept occurs in the done cycle.
  - Bits 0 and 1 go low again 1 cycle after done; no request is lost or duplicated.
